// File: rtl/maze_dfs_solver.sv
// Depth-first maze solver walking a 1-bit wall/visited map in external memory.
// The found path is kept on a move stack and can be replayed any number of times.
module maze_dfs_solver #(
    parameter int X_W = 4,
    parameter int Y_W = 4,
    localparam int A_W = X_W + Y_W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           run,
    output logic           mem_rd,
    output logic           mem_wr,
    output logic [A_W-1:0] mem_addr,
    input  logic           mem_rdata,
    output logic           busy,
    output logic           done,
    output logic           fail,
    output logic [X_W-1:0] x_o,
    output logic [Y_W-1:0] y_o,
    output logic [A_W-1:0] path_len,
    output logic [1:0]     move,
    output logic           move_valid,
    input  logic           move_ready
);
    // Replay handshake: a move transfers on a rising edge where move_valid and
    // move_ready are both high; until then move_valid stays high and move holds.

    typedef enum logic [3:0] {
        S_IDLE, S_INIT, S_PROBE, S_CHECK, S_MOVE, S_POP, S_DONE, S_FAIL, S_REPLAY
    } state_t;

    localparam logic [1:0]     DIR_UP    = 2'd0;
    localparam logic [1:0]     DIR_RIGHT = 2'd1;
    localparam logic [1:0]     DIR_LEFT  = 2'd2;
    localparam logic [1:0]     DIR_DOWN  = 2'd3;
    localparam logic [X_W-1:0] X_ONE     = X_W'(1);
    localparam logic [X_W-1:0] X_MAX     = '1;
    localparam logic [Y_W-1:0] Y_ONE     = Y_W'(1);
    localparam logic [Y_W-1:0] Y_MAX     = '1;
    localparam logic [A_W-1:0] A_ONE     = A_W'(1);

    state_t         state;
    logic [X_W-1:0] x, nx;
    logic [Y_W-1:0] y, ny;
    logic [1:0]     dir, top;
    logic           in_range, at_goal;
    logic [A_W-1:0] sp, idx;
    logic [1:0]     stack [2**A_W];

    // Neighbour of the current cell in the direction under test.
    always_comb begin
        nx       = x;
        ny       = y;
        in_range = 1'b0;
        case (dir)
            DIR_UP: begin
                in_range = (y != '0);
                ny       = y - Y_ONE;
            end
            DIR_RIGHT: begin
                in_range = (x != X_MAX);
                nx       = x + X_ONE;
            end
            DIR_LEFT: begin
                in_range = (x != '0);
                nx       = x - X_ONE;
            end
            default: begin
                in_range = (y != Y_MAX);
                ny       = y + Y_ONE;
            end
        endcase
    end

    assign at_goal = (nx == X_MAX) && (ny == Y_MAX);
    assign top     = stack[sp - A_ONE];

    always_comb begin
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        mem_addr = '0;
        case (state)
            S_INIT:  mem_wr = 1'b1;
            S_PROBE: begin
                mem_rd   = in_range;
                mem_addr = in_range ? {ny, nx} : '0;
            end
            S_MOVE: begin
                mem_wr   = 1'b1;
                mem_addr = {ny, nx};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            x          <= '0;
            y          <= '0;
            dir        <= DIR_UP;
            sp         <= '0;
            idx        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            fail       <= 1'b0;
            move_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_FAIL: begin
                    if (start) begin
                        state <= S_INIT;
                        sp    <= '0;
                        x     <= '0;
                        y     <= '0;
                        dir   <= DIR_UP;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                        fail  <= 1'b0;
                    end else if (state == S_DONE && run) begin
                        state      <= S_REPLAY;
                        idx        <= '0;
                        busy       <= 1'b1;
                        move_valid <= 1'b1;
                    end
                end
                S_INIT: state <= S_PROBE;
                S_PROBE: begin
                    if (in_range)             state <= S_CHECK;
                    else if (dir == DIR_DOWN) state <= S_POP;
                    else                      dir   <= dir + 2'd1;
                end
                S_CHECK: begin
                    if (!mem_rdata) begin
                        state <= S_MOVE;
                    end else if (dir == DIR_DOWN) begin
                        state <= S_POP;
                    end else begin
                        dir   <= dir + 2'd1;
                        state <= S_PROBE;
                    end
                end
                S_MOVE: begin
                    sp  <= sp + A_ONE;
                    x   <= nx;
                    y   <= ny;
                    dir <= DIR_UP;
                    if (at_goal) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        state <= S_PROBE;
                    end
                end
                S_POP: begin
                    if (sp == '0) begin
                        state <= S_FAIL;
                        fail  <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        // Undo the popped move and resume with the next direction after it.
                        sp <= sp - A_ONE;
                        case (top)
                            DIR_UP:    y <= y + Y_ONE;
                            DIR_RIGHT: x <= x - X_ONE;
                            DIR_LEFT:  x <= x + X_ONE;
                            default:   y <= y - Y_ONE;
                        endcase
                        dir   <= top + 2'd1;
                        state <= (top == DIR_DOWN) ? S_POP : S_PROBE;
                    end
                end
                S_REPLAY: begin
                    if (move_ready) begin
                        if (idx == sp - A_ONE) begin
                            state      <= S_DONE;
                            busy       <= 1'b0;
                            move_valid <= 1'b0;
                        end else begin
                            idx <= idx + A_ONE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && state == S_MOVE) stack[sp] <= dir;
    end

    assign move     = move_valid ? stack[idx] : 2'b00;
    assign path_len = sp;
    assign x_o      = x;
    assign y_o      = y;
endmodule

// File: tb/tb_maze_dfs_solver.sv
// Bench for maze_dfs_solver: a 2x2 and a 4x4 instance with behavioural memories,
// checked against a plain depth-first search model and fixed expected paths.
module tb_maze_dfs_solver;
    localparam int MX = 2;
    localparam int MY = 2;
    localparam int MA = 4;
    localparam logic [15:0] DEAD_WALLS = 16'h0624;  // walls at (2,0) (1,1) (1,2) (2,2)

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   checks = 0;
    int   failures = 0;

    // 4x4 instance
    logic          start, run, move_ready;
    logic          mem_rd, mem_wr;
    logic          mem_rdata = 1'b0;
    logic [MA-1:0] mem_addr, path_len;
    logic          busy, done, fail, move_valid;
    logic [MX-1:0] x_o;
    logic [MY-1:0] y_o;
    logic [1:0]    move;

    // 2x2 instance
    logic       s_start, s_run, s_move_ready;
    logic       s_mem_rd, s_mem_wr;
    logic       s_mem_rdata = 1'b0;
    logic [1:0] s_mem_addr, s_path_len;
    logic       s_busy, s_done, s_fail, s_move_valid;
    logic [0:0] s_x, s_y;
    logic [1:0] s_move;

    maze_dfs_solver #(.X_W(MX), .Y_W(MY)) dut (
        .clk(clk), .rst(rst), .start(start), .run(run),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .busy(busy), .done(done), .fail(fail), .x_o(x_o), .y_o(y_o),
        .path_len(path_len), .move(move), .move_valid(move_valid), .move_ready(move_ready)
    );

    maze_dfs_solver #(.X_W(1), .Y_W(1)) dut_s (
        .clk(clk), .rst(rst), .start(s_start), .run(s_run),
        .mem_rd(s_mem_rd), .mem_wr(s_mem_wr), .mem_addr(s_mem_addr), .mem_rdata(s_mem_rdata),
        .busy(s_busy), .done(s_done), .fail(s_fail), .x_o(s_x), .y_o(s_y),
        .path_len(s_path_len), .move(s_move), .move_valid(s_move_valid), .move_ready(s_move_ready)
    );

    // Behavioural memories: registered read, write always sets the bit.
    logic [15:0] mem_bits = '0, load_val;
    logic        load_en;
    logic [3:0]  s_bits = '0, s_load_val;
    logic        s_load_en;
    int          rd_cnt = 0, wr_cnt = 0, both_cnt = 0;

    always @(posedge clk) begin
        if (load_en) mem_bits <= load_val;
        else if (mem_wr) mem_bits[mem_addr] <= 1'b1;
        if (mem_rd) mem_rdata <= mem_bits[mem_addr];
        if (mem_rd) rd_cnt <= rd_cnt + 1;
        if (mem_wr) wr_cnt <= wr_cnt + 1;
        if ((mem_rd && mem_wr) || (s_mem_rd && s_mem_wr)) both_cnt <= both_cnt + 1;
    end

    always @(posedge clk) begin
        if (s_load_en) s_bits <= s_load_val;
        else if (s_mem_wr) s_bits[s_mem_addr] <= 1'b1;
        if (s_mem_rd) s_mem_rdata <= s_bits[s_mem_addr];
    end

    // Scoreboard and driver results
    logic [1:0] exp_q[$];
    logic [1:0] ref_path[$];
    logic [1:0] rp_got[$];
    int         rp_unstable;
    bit         rp_timeout;
    int         d_reads, d_writes;
    logic       first_busy;

    function automatic int dx(input int d);
        return (d == 1) ? 1 : (d == 2) ? -1 : 0;
    endfunction

    function automatic int dy(input int d);
        return (d == 0) ? -1 : (d == 3) ? 1 : 0;
    endfunction

    // Reference DFS: try up, right, left, down from each cell; backtrack on dead ends.
    task automatic ref_solve(input logic [15:0] walls, input int xw, input int yw,
                             output bit ok, output int reads, output int writes,
                             output int fx, output int fy, output logic [15:0] vis);
        int w, h, cx, cy, d, nx, ny;
        bit moved;
        logic [1:0] p;
        w = 1 << xw; h = 1 << yw;
        vis = walls; vis[0] = 1'b1;
        cx = 0; cy = 0; d = 0; reads = 0; writes = 1; ok = 0;
        ref_path.delete();
        for (int guard = 0; guard < 10000; guard++) begin
            if (cx == w - 1 && cy == h - 1) begin ok = 1; break; end
            moved = 0;
            while (d < 4 && !moved) begin
                nx = cx + dx(d); ny = cy + dy(d);
                if (nx >= 0 && nx < w && ny >= 0 && ny < h) begin
                    reads++;
                    if (!vis[ny * w + nx]) begin
                        vis[ny * w + nx] = 1'b1;
                        writes++;
                        ref_path.push_back(2'(d));
                        cx = nx; cy = ny; d = 0; moved = 1;
                    end else d++;
                end else d++;
            end
            if (!moved) begin
                if (ref_path.size() == 0) break;
                p = ref_path.pop_back();
                cx -= dx(int'(p)); cy -= dy(int'(p));
                d = int'(p) + 1;
            end
        end
        fx = cx; fy = cy;
    endtask

    // ---------------- drivers ----------------
    task automatic load_main(input logic [15:0] w);
        @(negedge clk); load_val = w; load_en = 1'b1;
        @(negedge clk); load_en = 1'b0;
    endtask

    task automatic load_small(input logic [3:0] w);
        @(negedge clk); s_load_val = w; s_load_en = 1'b1;
        @(negedge clk); s_load_en = 1'b0;
    endtask

    task automatic search_main(input int poke_at, output bit fin);
        int r0, w0;
        fin = 0;
        r0 = rd_cnt; w0 = wr_cnt;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        first_busy = busy;
        for (int c = 0; c < 2000; c++) begin
            if (done || fail) begin fin = 1; break; end
            start = (c == poke_at);
            @(negedge clk);
        end
        start = 1'b0;
        d_reads = rd_cnt - r0;
        d_writes = wr_cnt - w0;
    endtask

    task automatic search_small(output bit fin);
        fin = 0;
        @(negedge clk); s_start = 1'b1;
        @(negedge clk); s_start = 0;
        for (int c = 0; c < 500; c++) begin
            if (s_done || s_fail) begin fin = 1; break; end
            @(negedge clk);
        end
    endtask

    // mode 0: ready always high, 1: ready pattern 1,0,0,1, 2: random ready
    task automatic replay_main(input int mode, input int n);
        logic [1:0] held;
        bit hold, rdy;
        rp_got.delete(); rp_unstable = 0; rp_timeout = 1; hold = 0; held = 2'b00;
        @(negedge clk); run = 1'b1;
        @(negedge clk); run = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (rp_got.size() == n) begin rp_timeout = 0; break; end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (c % 4 == 0) || (c % 4 == 3);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            move_ready = rdy;
            if (!move_valid || (hold && move !== held)) rp_unstable++;
            if (rdy) begin rp_got.push_back(move); hold = 0; end
            else begin hold = 1; held = move; end
            @(negedge clk);
        end
        move_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, fail, mem_rd, mem_wr, move_valid, move, x_o, y_o, path_len, mem_addr} !== '0) begin
            failures++; $display("FAIL reset_main: got outputs nonzero (done=%b busy=%b len=%0d) want all 0", done, busy, path_len);
        end
        checks++;
        if ({s_busy, s_done, s_fail, s_mem_rd, s_mem_wr, s_move_valid, s_move, s_x, s_y, s_path_len, s_mem_addr} !== '0) begin
            failures++; $display("FAIL reset_small: got outputs nonzero want all 0");
        end
        rst = 1'b0;
    endtask

    task automatic test_small_open();
        bit fin;
        load_small(4'b0000);
        search_small(fin);
        checks++; if (!fin) begin failures++; $display("FAIL small_open_timeout: no done/fail"); end
        checks++; if ({s_done, s_fail} !== 2'b10) begin failures++; $display("FAIL small_open_flags: got %b want 10", {s_done, s_fail}); end
        checks++; if (s_path_len !== 2'd2) begin failures++; $display("FAIL small_open_len: got %0d want 2", s_path_len); end
        checks++; if ({s_y, s_x} !== 2'b11) begin failures++; $display("FAIL small_open_pos: got %b want 11", {s_y, s_x}); end
        checks++; if (s_bits !== 4'b1011) begin failures++; $display("FAIL small_open_mem: got %b want 1011", s_bits); end
        s_move_ready = 1'b1;
        @(negedge clk); s_run = 1'b1;
        @(negedge clk); s_run = 1'b0;
        checks++; if ({s_move_valid, s_move} !== 3'b101) begin failures++; $display("FAIL small_replay_0: got %b want 101", {s_move_valid, s_move}); end
        @(negedge clk);
        checks++; if ({s_move_valid, s_move} !== 3'b111) begin failures++; $display("FAIL small_replay_1: got %b want 111", {s_move_valid, s_move}); end
        @(negedge clk);
        checks++; if ({s_move_valid, s_done, s_busy} !== 3'b010) begin failures++; $display("FAIL small_replay_end: got %b want 010", {s_move_valid, s_done, s_busy}); end
        s_move_ready = 1'b0;
    endtask

    task automatic test_small_blocked();
        bit fin;
        load_small(4'b0110);
        search_small(fin);
        checks++; if (!fin) begin failures++; $display("FAIL small_block_timeout: no done/fail"); end
        checks++; if ({s_done, s_fail, s_busy} !== 3'b010) begin failures++; $display("FAIL small_block_flags: got %b want 010", {s_done, s_fail, s_busy}); end
        checks++; if ({s_path_len, s_y, s_x} !== 4'b0000) begin failures++; $display("FAIL small_block_state: got %b want 0000", {s_path_len, s_y, s_x}); end
        @(negedge clk); s_run = 1'b1;
        @(negedge clk); s_run = 1'b0;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if ({s_busy, s_move_valid, s_done, s_fail} !== 4'b0001) begin
                failures++; $display("FAIL run_in_fail: got %b want 0001", {s_busy, s_move_valid, s_done, s_fail});
            end
            @(negedge clk);
        end
    endtask

    task automatic test_dead_end();
        bit fin, ok;
        int reads, writes, fx, fy;
        logic [15:0] vis;
        load_main(DEAD_WALLS);
        search_main(-1, fin);
        ref_solve(DEAD_WALLS, MX, MY, ok, reads, writes, fx, fy, vis);
        checks++; if (!fin) begin failures++; $display("FAIL dead_timeout: no done/fail"); end
        checks++; if (first_busy !== 1'b1) begin failures++; $display("FAIL dead_busy: got %b want 1", first_busy); end
        checks++; if ({done, fail} !== 2'b10) begin failures++; $display("FAIL dead_flags: got %b want 10", {done, fail}); end
        checks++; if (path_len !== 4'd6) begin failures++; $display("FAIL dead_len: got %0d want 6", path_len); end
        checks++; if ({y_o, x_o} !== 4'b1111) begin failures++; $display("FAIL dead_pos: got %b want 1111", {y_o, x_o}); end
        checks++; if (d_reads !== reads) begin failures++; $display("FAIL dead_reads: got %0d want %0d", d_reads, reads); end
        checks++; if (d_writes !== writes) begin failures++; $display("FAIL dead_writes: got %0d want %0d", d_writes, writes); end
        checks++; if (mem_bits !== vis) begin failures++; $display("FAIL dead_mem: got %h want %h", mem_bits, vis); end
        for (int r = 0; r < 2; r++) begin
            exp_q = '{2'b11, 2'b11, 2'b11, 2'b01, 2'b01, 2'b01};
            replay_main((r == 0) ? 1 : 0, 6);
            checks++; if (rp_timeout) begin failures++; $display("FAIL dead_replay%0d_timeout: got %0d moves want 6", r, rp_got.size()); end
            checks++; if (rp_unstable !== 0) begin failures++; $display("FAIL dead_replay%0d_stable: got %0d glitches want 0", r, rp_unstable); end
            foreach (rp_got[i]) begin
                checks++;
                if (exp_q.size() == 0 || rp_got[i] !== exp_q[0]) begin
                    failures++; $display("FAIL dead_replay%0d_move%0d: got %b want %b", r, i, rp_got[i], (exp_q.size() != 0) ? exp_q[0] : 2'bxx);
                end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
            checks++; if ({move_valid, done, busy} !== 3'b010) begin failures++; $display("FAIL dead_replay%0d_end: got %b want 010", r, {move_valid, done, busy}); end
            checks++; if (path_len !== 4'd6) begin failures++; $display("FAIL dead_replay%0d_len: got %0d want 6", r, path_len); end
        end
    endtask

    task automatic test_start_ignored();
        bit fin, ok;
        int reads, writes, fx, fy;
        logic [15:0] vis;
        load_main(DEAD_WALLS);
        search_main(3, fin);
        ref_solve(DEAD_WALLS, MX, MY, ok, reads, writes, fx, fy, vis);
        checks++; if (!fin || {done, fail} !== 2'b10) begin failures++; $display("FAIL start_ign_flags: got %b want 10", {done, fail}); end
        checks++; if (path_len !== 4'(ref_path.size())) begin failures++; $display("FAIL start_ign_len: got %0d want %0d", path_len, ref_path.size()); end
        checks++; if (d_reads !== reads || d_writes !== writes) begin
            failures++; $display("FAIL start_ign_traffic: got rd=%0d wr=%0d want rd=%0d wr=%0d", d_reads, d_writes, reads, writes);
        end
    endtask

    task automatic test_run_ignored();
        int r0, w0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        r0 = rd_cnt; w0 = wr_cnt;
        run = 1'b1;
        @(negedge clk); run = 1'b0;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if ({busy, move_valid, done, fail} !== 4'b0000 || rd_cnt != r0 || wr_cnt != w0) begin
                failures++; $display("FAIL run_in_idle: got %b rd+%0d wr+%0d want 0000 no traffic", {busy, move_valid, done, fail}, rd_cnt - r0, wr_cnt - w0);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_search();
        bit fin;
        int r0, w0;
        load_main(DEAD_WALLS);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL midrst_busy_before: got %b want 1", busy); end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done, fail, mem_rd, mem_wr, move_valid, move, x_o, y_o, path_len, mem_addr} !== '0) begin
            failures++; $display("FAIL midrst_outputs: got busy=%b pos=%0d,%0d len=%0d rd=%b want all 0", busy, x_o, y_o, path_len, mem_rd);
        end
        rst = 1'b0;
        r0 = rd_cnt; w0 = wr_cnt;
        repeat (3) @(negedge clk);
        checks++; if (rd_cnt != r0 || wr_cnt != w0) begin failures++; $display("FAIL midrst_traffic: got rd+%0d wr+%0d want 0", rd_cnt - r0, wr_cnt - w0); end
        load_main(DEAD_WALLS);
        search_main(-1, fin);
        checks++; if (!fin || {done, fail} !== 2'b10) begin failures++; $display("FAIL midrst_resolve: got %b want 10", {done, fail}); end
        checks++; if ({path_len, y_o, x_o} !== 8'h6F) begin failures++; $display("FAIL midrst_result: got %h want 6f", {path_len, y_o, x_o}); end
    endtask

    task automatic test_random();
        bit fin, ok;
        int reads, writes, fx, fy;
        logic [15:0] walls, vis;
        for (int t = 0; t < 10; t++) begin
            walls = '0;
            for (int i = 1; i < 16; i++) if ($urandom_range(0, 99) < 30) walls[i] = 1'b1;
            load_main(walls);
            search_main(-1, fin);
            ref_solve(walls, MX, MY, ok, reads, writes, fx, fy, vis);
            checks++; if (!fin || {done, fail} !== {ok, !ok}) begin
                failures++; $display("FAIL rand%0d_flags: maze %h got %b want %b", t, walls, {done, fail}, {ok, !ok});
            end
            checks++; if ({path_len, y_o, x_o} !== {4'(ref_path.size()), 2'(fy), 2'(fx)}) begin
                failures++; $display("FAIL rand%0d_state: maze %h got len=%0d pos=%0d,%0d want len=%0d pos=%0d,%0d", t, walls, path_len, x_o, y_o, ref_path.size(), fx, fy);
            end
            checks++; if (d_reads !== reads || d_writes !== writes || mem_bits !== vis) begin
                failures++; $display("FAIL rand%0d_mem: got rd=%0d wr=%0d map=%h want rd=%0d wr=%0d map=%h", t, d_reads, d_writes, mem_bits, reads, writes, vis);
            end
            if (ok && done) begin
                exp_q = ref_path;
                replay_main(2, ref_path.size());
                checks++; if (rp_timeout || rp_unstable !== 0) begin
                    failures++; $display("FAIL rand%0d_handshake: got %0d moves %0d glitches want %0d moves 0 glitches", t, rp_got.size(), rp_unstable, ref_path.size());
                end
                foreach (rp_got[i]) begin
                    checks++;
                    if (exp_q.size() == 0 || rp_got[i] !== exp_q[0]) begin
                        failures++; $display("FAIL rand%0d_move%0d: got %b want %b", t, i, rp_got[i], (exp_q.size() != 0) ? exp_q[0] : 2'bxx);
                    end
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                end
                checks++; if ({move_valid, done, busy} !== 3'b010) begin failures++; $display("FAIL rand%0d_end: got %b want 010", t, {move_valid, done, busy}); end
            end
        end
    endtask

    task automatic test_mem_protocol();
        checks++;
        if (both_cnt !== 0) begin failures++; $display("FAIL mem_rd_wr_overlap: got %0d cycles want 0", both_cnt); end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; run = 1'b0; move_ready = 1'b0;
        s_start = 1'b0; s_run = 1'b0; s_move_ready = 1'b0;
        load_en = 1'b0; load_val = '0; s_load_en = 1'b0; s_load_val = '0;
        test_reset();
        test_small_open();
        test_small_blocked();
        test_dead_end();
        test_start_ignored();
        test_run_ignored();
        test_reset_mid_search();
        test_random();
        test_mem_protocol();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/maze_dfs_solver.md
# maze_dfs_solver

Parametrised depth-first maze solver for grids of 2^X_W by 2^Y_W cells. It walks a one-bit-per-cell wall/visited map held in an external single-port memory, starting at (0,0) and searching for the far corner (2^X_W-1, 2^Y_W-1), and records the path on an internal move stack. After a successful search it replays the path as a stream of 2-bit moves under a valid/ready handshake. It is the generalised successor of the fixed 16x16 rat-in-maze solver: grid size is parametrised, memory access is an explicit port, and replay supports back-pressure and can be repeated.

## Interface
- X_W, 4, x coordinate width; grid width = 2^X_W (X_W >= 1)
- Y_W, 4, y coordinate width; grid height = 2^Y_W (Y_W >= 1)
- A_W, X_W+Y_W, derived: memory address, stack pointer and path_len width
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  pulse; begins a search when in IDLE, DONE or FAIL
- run  in  1  pulse; begins path replay when in DONE
- mem_rd  out  1  read strobe
- mem_wr  out  1  write strobe; write data is always 1 (mark visited)
- mem_addr  out  A_W  cell address {y, x}
- mem_rdata  in  1  cell value, valid exactly one cycle after mem_rd; 1 = wall or visited
- busy  out  1  high while searching or replaying
- done  out  1  level; high from search success until next start or rst
- fail  out  1  level; high from search failure until next start or rst
- x_o, y_o  out  X_W, Y_W  current position
- path_len  out  A_W  number of moves on the stack
- move  out  2  replayed move: 00 up (y-1), 01 right (x+1), 10 left (x-1), 11 down (y+1)
- move_valid  out  1  move is valid
- move_ready  in  1  consumer accepts move when valid and ready are both high

## Operation
- States: IDLE, INIT, PROBE, CHECK, MOVE, POP, DONE, FAIL, REPLAY.
- Reset: state IDLE; all outputs 0; position (0,0); stack pointer 0; dir 0.
- IDLE/DONE/FAIL + start -> INIT: clear the stack, done and fail; set position to (0,0) and dir to 0. start is ignored in the other states.
- INIT: write 1 to address 0, because the origin is treated as open and visited -> PROBE.
- PROBE, dir = d: compute the neighbour in direction d.
  - If the neighbour is out of range: for d < 3, set d += 1 and stay in PROBE; for d = 3, go to POP.
  - If in range: assert mem_rd at the neighbour address -> CHECK.
- CHECK: if mem_rdata = 1, advance dir as in PROBE (d < 3 -> PROBE with d+1; d = 3 -> POP). If 0 -> MOVE.
- MOVE: mem_wr to the neighbour address; push d; update position; set dir to 0. If the new position is the goal -> DONE, otherwise -> PROBE.
- POP, stack empty: -> FAIL.
- POP, stack not empty: pop p; move position by the opposite direction (3-p); set dir to p+1 -> PROBE. If p = 3 -> POP again.
- DONE + run -> REPLAY with replay index 0. run is ignored in the other states. Simultaneous start and run in DONE: start wins.
- REPLAY: move = stack[index] and move_valid = 1. On handshake, index += 1. Once the last entry is accepted -> DONE, and the same path can be replayed again.
- path_len = stack pointer. It is held through DONE and REPLAY.
- The memory is never cleared by this block. Visited marks persist, so the maze must be reloaded before the next start.
- rst mid-search or mid-replay: IDLE on the next edge, no further memory access. Memory contents are left as written.

## Timing
- Out-of-range probe: 1 cycle. In-range probe: 2 cycles (PROBE issues mem_rd, CHECK consumes mem_rdata). MOVE: 1 cycle. POP: 1 cycle.
- mem_rd and mem_wr are never high in the same cycle. At most one memory access per cycle.
- done and fail are registered and rise in the cycle after the deciding MOVE or POP.
- REPLAY: the first move_valid appears the cycle after run. Throughput is 1 move per cycle with move_ready held high. move and move_valid stay stable while move_ready is low.
- busy is high in INIT through POP and in REPLAY; it is low in IDLE, DONE and FAIL.

## Test plan
- X_W=Y_W=1, all cells open, start -> moves pushed 01 then 11; done=1, path_len=2, position (1,1). Then run with move_ready=1 -> move 01 then 11 on consecutive cycles, then back in DONE.
- X_W=Y_W=1, cells (1,0) and (0,1) are walls -> fail=1, path_len=0, position (0,0), done=0.
- X_W=Y_W=2, dead end at (1,0) with the only route going down from the origin -> POP returns to (0,0), search resumes at dir 2. Final path is 11,11,11,01,01,01; path_len=6.
- Replay with move_ready toggling 1,0,0,1,... -> each move held stable while not ready; no move skipped or duplicated. Second run replays an identical sequence.
- rst asserted mid-search -> next cycle all outputs 0 and state IDLE; a later start with the maze reloaded succeeds normally.
- start pulsed during search and run pulsed in IDLE or FAIL -> both ignored; no change to state or memory traffic.
